// File: rtl/if_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - default bus widths and discard-counter width
//   - fetch FSM state type and encodings
//   - helper that merges the two flush sources into one flush request
// -----------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 2;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;
    localparam fetch_state_t ST_HOLD = 2'd3;

    // Exceptions and branch mispredicts cancel in-flight fetches identically.
    function automatic logic combine_flush(input logic excep_flush,
                                           input logic branch_flush);
        return excep_flush | branch_flush;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_discard_cnt.sv
// -----------------------------------------------------------------------------
// if_discard_cnt
// Saturating up/down counter of bus responses still owed to cancelled
// requests. Simultaneous inc and dec leave the count unchanged.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   inc          a cancelled request now owes a response
//   dec          a response for a cancelled request arrived
//   count        current number of owed responses
//   at_max       count is saturated; new fetches must wait
//   is_zero      no owed responses; next data_ok belongs to the live request
// -----------------------------------------------------------------------------
module if_discard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign at_max  = (count == CNT_MAX);
    assign is_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + CNT_ONE;
        end else if (dec && !inc && !is_zero) begin
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer on an SRAM-like bus (req/addr_ok/data_ok,
// in-order responses). Takes a PC from the PC generator, issues one request,
// holds the returned instruction until the IF/ID register accepts it, and
// drops responses that belong to requests cancelled by a flush.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pc_valid_i, pc_i  fetch address offered by the PC generator
//   fetch_go_o        pc_i accepted this cycle (combinational pulse)
//   inst_req_o        bus request, inst_addr_o its address
//   inst_addr_ok_i    bus accepted the address
//   inst_data_ok_i    bus returns data on inst_rdata_i
//   excep_flush_i     exception flush
//   branch_flush_i    branch-mispredict flush
//   now_allowin_i     IF/ID register can accept
//   out_valid_o       instruction in out_pc_o/out_inst_o is valid
// -----------------------------------------------------------------------------
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              fetch_go_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    input  logic              excep_flush_i,
    input  logic              branch_flush_i,
    input  logic              now_allowin_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [DATA_W-1:0] out_inst_o
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] inst_r;
    logic              cancel_flag;

    logic              flush;
    logic              stale_rsp;
    logic              live_rsp;
    logic              cnt_inc;
    logic [CNT_W-1:0]  discard_cnt;
    logic              cnt_at_max;
    logic              cnt_zero;

    assign flush = combine_flush(excep_flush_i, branch_flush_i);

    // A response is stale whenever cancelled requests still owe responses,
    // because the bus answers strictly in order.
    assign stale_rsp = inst_data_ok_i && !cnt_zero;
    assign live_rsp  = inst_data_ok_i && cnt_zero;

    assign fetch_go_o  = (state == ST_IDLE) && pc_valid_i && !flush && !cnt_at_max;
    assign inst_req_o  = (state == ST_REQ);
    assign inst_addr_o = pc_r;
    assign out_valid_o = (state == ST_HOLD);
    assign out_pc_o    = pc_r;
    assign out_inst_o  = inst_r;

    // A request becomes owed-but-unwanted when its address is accepted after
    // (or together with) a flush, or when a flush hits while waiting for data
    // that has not yet arrived this cycle.
    always_comb begin
        cnt_inc = 1'b0;
        case (state)
            ST_REQ:  cnt_inc = inst_addr_ok_i && (cancel_flag || flush);
            ST_WAIT: cnt_inc = flush && !live_rsp;
            default: cnt_inc = 1'b0;
        endcase
    end

    if_discard_cnt #(
        .CNT_W(CNT_W)
    ) u_discard_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (cnt_inc),
        .dec    (stale_rsp),
        .count  (discard_cnt),
        .at_max (cnt_at_max),
        .is_zero(cnt_zero)
    );

    // Next-state logic. The request stays up with a stable address until
    // addr_ok, even if a flush arrives in between; the flush is remembered in
    // cancel_flag instead.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (fetch_go_o) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inst_addr_ok_i) begin
                    state_nxt = (cancel_flag || flush) ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stale_rsp) begin
                    if (flush) begin
                        state_nxt = ST_IDLE;
                    end
                end else if (live_rsp) begin
                    state_nxt = flush ? ST_IDLE : ST_HOLD;
                end else if (flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush || now_allowin_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, captured PC/instruction and the pending-cancel marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc_r        <= '0;
            inst_r      <= '0;
            cancel_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch_go_o) begin
                pc_r <= pc_i;
            end
            if ((state == ST_WAIT) && live_rsp && !flush) begin
                inst_r <= inst_rdata_i;
            end
            if (state == ST_REQ) begin
                if (inst_addr_ok_i) begin
                    cancel_flag <= 1'b0;
                end else if (flush) begin
                    cancel_flag <= 1'b1;
                end
            end
        end
    end

    // Counter value is only needed internally for the zero/max flags.
    logic unused_cnt;
    assign unused_cnt = ^discard_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the fetch
// unit and a simple in-order bus responder.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam int STALE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        fetch_go_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        excep_flush_i;
    logic        branch_flush_i;
    logic        now_allowin_i;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_valid_i    (pc_valid_i),
        .pc_i          (pc_i),
        .fetch_go_o    (fetch_go_o),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i),
        .inst_data_ok_i(inst_data_ok_i),
        .inst_rdata_i  (inst_rdata_i),
        .excep_flush_i (excep_flush_i),
        .branch_flush_i(branch_flush_i),
        .now_allowin_i (now_allowin_i),
        .out_valid_o   (out_valid_o),
        .out_pc_o      (out_pc_o),
        .out_inst_o    (out_inst_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: what the fetch unit is doing, expressed as flags.
    bit          m_fetching;   // request on the bus, address not yet taken
    bit          m_awaiting;   // address taken, waiting for our data
    bit          m_holding;    // instruction waiting for IF/ID
    bit          m_cancel;     // current request already killed by a flush
    int          m_stale;      // responses still owed to killed requests
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    int          bus_pending;  // bus responder: accepted, unanswered requests

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        bit idle;
        bit flush;
        bit exp_go;
        idle   = !(m_fetching || m_awaiting || m_holding);
        flush  = excep_flush_i || branch_flush_i;
        exp_go = idle && pc_valid_i && !flush && (m_stale < STALE_MAX);
        check_value("fetch_go",  {31'b0, fetch_go_o},  {31'b0, exp_go});
        check_value("inst_req",  {31'b0, inst_req_o},  {31'b0, m_fetching});
        check_value("out_valid", {31'b0, out_valid_o}, {31'b0, m_holding});
        check_value("inst_addr", inst_addr_o, m_pc);
        check_value("out_pc",    out_pc_o,    m_pc);
        check_value("out_inst",  out_inst_o,  m_inst);
    endtask

    // Drive one cycle of inputs (addr_ok/data_ok are masked so the bus stays
    // protocol-legal), check outputs, then advance the model across the edge.
    task automatic applyStimulus(input bit rst, input bit pv, input logic [31:0] pc,
                                 input bit aok, input bit dok, input logic [31:0] rd,
                                 input bit exc, input bit br, input bit alw);
        bit aok_e, dok_e, flush, idle, go, stale_rsp;
        aok_e = aok && m_fetching;
        dok_e = dok && (bus_pending > 0);
        rst_n          = !rst;
        pc_valid_i     = pv;
        pc_i           = pc;
        inst_addr_ok_i = aok_e;
        inst_data_ok_i = dok_e;
        inst_rdata_i   = rd;
        excep_flush_i  = exc;
        branch_flush_i = br;
        now_allowin_i  = alw;
        #1;
        checkOutput();
        @(posedge clk);
        flush     = exc || br;
        idle      = !(m_fetching || m_awaiting || m_holding);
        go        = idle && pv && !flush && (m_stale < STALE_MAX);
        stale_rsp = dok_e && (m_stale > 0);
        if (rst) begin
            m_fetching = 0; m_awaiting = 0; m_holding = 0; m_cancel = 0;
            m_stale = 0; m_pc = '0; m_inst = '0; bus_pending = 0;
        end else begin
            if (aok_e) bus_pending++;
            if (dok_e) bus_pending--;
            if (stale_rsp) m_stale--;
            if (go) begin
                m_pc = pc;
                m_fetching = 1;
            end else if (m_fetching) begin
                if (aok_e) begin
                    m_fetching = 0;
                    if (m_cancel || flush) begin
                        m_stale++;
                        m_cancel = 0;
                    end else begin
                        m_awaiting = 1;
                    end
                end else if (flush) begin
                    m_cancel = 1;
                end
            end else if (m_awaiting) begin
                if (stale_rsp) begin
                    if (flush) begin
                        m_awaiting = 0;
                        m_stale++;
                    end
                end else if (dok_e) begin
                    m_awaiting = 0;
                    if (!flush) begin
                        m_holding = 1;
                        m_inst = rd;
                    end
                end else if (flush) begin
                    m_awaiting = 0;
                    m_stale++;
                end
            end else if (m_holding) begin
                if (flush || alw) m_holding = 0;
            end
            if (m_stale > STALE_MAX) m_stale = STALE_MAX;
        end
        @(negedge clk);
    endtask

    // Shorthand for a normal (non-reset) cycle.
    task automatic step(input bit pv, input logic [31:0] pc, input bit aok,
                        input bit dok, input logic [31:0] rd, input bit exc,
                        input bit br, input bit alw);
        applyStimulus(1'b0, pv, pc, aok, dok, rd, exc, br, alw);
    endtask

    initial begin
        m_fetching = 0; m_awaiting = 0; m_holding = 0; m_cancel = 0;
        m_stale = 0; m_pc = '0; m_inst = '0; bus_pending = 0;
        rst_n = 0; pc_valid_i = 0; pc_i = '0; inst_addr_ok_i = 0;
        inst_data_ok_i = 0; inst_rdata_i = '0; excep_flush_i = 0;
        branch_flush_i = 0; now_allowin_i = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, '0, 0, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, '0, 0, 0, 0);

        // Basic fetch
        step(1, 32'h1C000000, 0, 0, '0, 0, 0, 1);
        step(0, '0, 1, 0, '0, 0, 0, 1);
        step(0, '0, 0, 0, '0, 0, 0, 1);
        step(0, '0, 0, 1, 32'h02800C0C, 0, 0, 1);
        check_value("basic_valid", {31'b0, out_valid_o}, 32'd1);
        check_value("basic_pc",    out_pc_o,   32'h1C000000);
        check_value("basic_inst",  out_inst_o, 32'h02800C0C);
        step(0, '0, 0, 0, '0, 0, 0, 1);
        check_value("basic_done", {31'b0, out_valid_o}, 32'd0);

        // Stall in HOLD for 5 cycles, transfer on the 6th
        step(1, 32'h1C000004, 0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 32'h12345678, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check_value("stall_inst", out_inst_o, 32'h12345678);
            step(0, '0, 0, 0, '0, 0, 0, 0);
        end
        step(0, '0, 0, 0, '0, 0, 0, 1);

        // Branch flush in WAIT, stale response dropped
        step(1, 32'h1C000010, 0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 0, '0, 0, 1, 0);
        step(1, 32'h1C000040, 0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 32'hDEADBEEF, 0, 0, 0);
        check_value("wflush_drop", {31'b0, out_valid_o}, 32'd0);
        step(0, '0, 0, 1, 32'h00112233, 0, 0, 0);
        check_value("wflush_pc",   out_pc_o,   32'h1C000040);
        check_value("wflush_inst", out_inst_o, 32'h00112233);
        step(0, '0, 0, 0, '0, 0, 0, 1);

        // Exception flush in REQ, addr_ok three cycles late
        step(1, 32'h1C000080, 0, 0, '0, 0, 0, 0);
        step(0, '0, 0, 0, '0, 1, 0, 0);
        step(0, '0, 0, 0, '0, 0, 0, 0);
        check_value("rflush_addr", inst_addr_o, 32'h1C000080);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 32'hCAFEF00D, 0, 0, 0);
        check_value("rflush_novalid", {31'b0, out_valid_o}, 32'd0);

        // Saturation: three flushed requests with no responses
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h1C000100 + 32'(i * 4), 0, 0, '0, 0, 0, 0);
            step(0, '0, 1, 0, '0, 0, 1, 0);
        end
        pc_valid_i = 1;
        #1;
        check_value("sat_blocked", {31'b0, fetch_go_o}, 32'd0);
        step(1, 32'h1C000200, 0, 1, '0, 0, 0, 0);
        pc_valid_i = 1;
        #1;
        check_value("sat_unblocked", {31'b0, fetch_go_o}, 32'd1);
        step(1, 32'h1C000200, 0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 32'h11111111, 0, 0, 0);
        step(0, '0, 0, 1, 32'h22222222, 0, 0, 0);
        step(0, '0, 0, 1, 32'h33333333, 0, 0, 0);
        check_value("sat_inst", out_inst_o, 32'h33333333);
        step(0, '0, 0, 0, '0, 0, 0, 1);

        // Reset while holding an instruction
        step(1, 32'h1C000300, 0, 0, '0, 0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 32'h0BADF00D, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, '0, 0, 0, 0);
        check_value("rst_valid", {31'b0, out_valid_o}, 32'd0);
        check_value("rst_req",   {31'b0, inst_req_o},  32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) < 7),
                          $urandom,
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 9) < 4),
                          $urandom,
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
